// File: rtl/rgb_video_rx_if.sv
// rtl/rgb_video_rx_if.sv - RGB video input bus plus forwarded pixel stream and status.
// Defining RGB_VIDEO_RX_SUM_EN adds the o_frame_sum member.
interface rgb_video_rx_if;
    logic        i_HS;
    logic        i_VS;
    logic        i_DE;
    logic [7:0]  i_Red;
    logic [7:0]  i_Green;
    logic [7:0]  i_Blue;
    logic        o_pix_valid;
    logic [7:0]  o_Red;
    logic [7:0]  o_Green;
    logic [7:0]  o_Blue;
    logic [15:0] o_col;
    logic [15:0] o_row;
    logic        o_sof;
    logic        o_eol;
    logic        o_eof;
    logic        o_locked;
    logic        o_err_h;
    logic        o_err_v;
`ifdef RGB_VIDEO_RX_SUM_EN
    logic [23:0] o_frame_sum;
`endif

    modport master (
        output i_HS, i_VS, i_DE, i_Red, i_Green, i_Blue,
`ifdef RGB_VIDEO_RX_SUM_EN
        input  o_frame_sum,
`endif
        input  o_pix_valid, o_Red, o_Green, o_Blue, o_col, o_row,
        input  o_sof, o_eol, o_eof, o_locked, o_err_h, o_err_v
    );

    modport slave (
        input  i_HS, i_VS, i_DE, i_Red, i_Green, i_Blue,
`ifdef RGB_VIDEO_RX_SUM_EN
        output o_frame_sum,
`endif
        output o_pix_valid, o_Red, o_Green, o_Blue, o_col, o_row,
        output o_sof, o_eol, o_eof, o_locked, o_err_h, o_err_v
    );
endinterface

// File: rtl/rgb_video_rx.sv
// rtl/rgb_video_rx.sv - DE-driven RGB frame receiver: geometry check, pixel coordinates, lock tracking.
// Optional RGB_VIDEO_RX_SUM_EN adds a per-frame R+G+B checksum output.
module rgb_video_rx #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input logic           i_clk,
    input logic           i_rst_n,
    rgb_video_rx_if.slave vid
);
    localparam logic [15:0] H_N    = 16'(H_ACTIVE);
    localparam logic [15:0] H_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] LOCK_N = 16'(LOCK_FRAMES);

    typedef enum logic [2:0] {SEEK, VBLANK, LINE, HGAP, DRAIN} state_t;

    state_t state_q, state_d;

    logic       unused_hs_q;
    logic       vs_q, de_q, vs_p_q, de_p_q;
    logic [7:0] r_q, g_q, b_q;

    logic [15:0] col_q, col_d, row_q, row_d;
    logic        ovf_q, ovf_d;
    logic [15:0] cnt_q, cnt_d;
    logic        frame_err_q, frame_err_d;

    logic        pv_q, pv_d;
    logic [7:0]  pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic [15:0] pcol_q, pcol_d, prow_q, prow_d;
    logic        psof_q, psof_d, peol_q, peol_d, peof_q, peof_d;
    logic        perr_h_q, perr_h_d, perr_v_q, perr_v_d;

    logic vs_fall, de_rise, de_fall;
    logic take, fwd, err_h, err_v, any_err;

    assign vs_fall = vs_p_q & ~vs_q;
    assign de_rise = de_q & ~de_p_q;
    assign de_fall = de_p_q & ~de_q;

    // Input registers plus one-cycle-old copies for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            unused_hs_q <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            vs_p_q      <= 1'b0;
            de_p_q      <= 1'b0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
        end else begin
            unused_hs_q <= vid.i_HS;
            vs_q        <= vid.i_VS;
            de_q        <= vid.i_DE;
            vs_p_q      <= vs_q;
            de_p_q      <= de_q;
            r_q         <= vid.i_Red;
            g_q         <= vid.i_Green;
            b_q         <= vid.i_Blue;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= SEEK;
            col_q       <= 16'd0;
            row_q       <= 16'd0;
            ovf_q       <= 1'b0;
            cnt_q       <= 16'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A VS fall always wins over DE edges; col is already 0 whenever a line starts.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ovf_d   = ovf_q;
        take    = 1'b0;
        err_h   = 1'b0;
        err_v   = 1'b0;
        case (state_q)
            SEEK: begin
                if (vs_fall) begin
                    state_d = VBLANK;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    ovf_d   = 1'b0;
                end
            end
            VBLANK, HGAP: begin
                if (vs_fall) begin
                    err_v   = 1'b1;
                    state_d = VBLANK;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    ovf_d   = 1'b0;
                end else if (de_rise) begin
                    state_d = LINE;
                    take    = 1'b1;
                end
            end
            LINE: begin
                if (vs_fall) begin
                    err_v   = 1'b1;
                    state_d = VBLANK;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    ovf_d   = 1'b0;
                end else if (de_fall) begin
                    err_h   = (col_q != H_N) || ovf_q;
                    row_d   = row_q + 16'd1;
                    col_d   = 16'd0;
                    ovf_d   = 1'b0;
                    state_d = (row_q == V_LAST) ? DRAIN : HGAP;
                end else if (de_q) begin
                    take = 1'b1;
                end
            end
            DRAIN: begin
                if (vs_fall) begin
                    state_d = VBLANK;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    ovf_d   = 1'b0;
                end else if (de_rise) begin
                    err_v = 1'b1;
                end
            end
            default: state_d = SEEK;
        endcase
        fwd = take && (col_q < H_N);
        if (take) begin
            if (fwd) begin
                col_d = col_q + 16'd1;
            end else begin
                col_d = H_N;
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        any_err     = err_h | err_v;
        frame_err_d = vs_fall ? 1'b0 : (frame_err_q | any_err);
        cnt_d       = cnt_q;
        if (any_err) begin
            cnt_d = 16'd0;
        end else if (vs_fall && state_q == DRAIN && !frame_err_q && cnt_q < LOCK_N) begin
            cnt_d = cnt_q + 16'd1;
        end
        pv_d     = fwd;
        pr_d     = fwd ? r_q : pr_q;
        pg_d     = fwd ? g_q : pg_q;
        pb_d     = fwd ? b_q : pb_q;
        pcol_d   = fwd ? col_q : pcol_q;
        prow_d   = fwd ? row_q : prow_q;
        psof_d   = fwd && col_q == 16'd0 && row_q == 16'd0;
        peol_d   = fwd && col_q == H_LAST;
        peof_d   = fwd && col_q == H_LAST && row_q == V_LAST;
        perr_h_d = err_h;
        perr_v_d = err_v;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pv_q     <= 1'b0;
            pr_q     <= 8'd0;
            pg_q     <= 8'd0;
            pb_q     <= 8'd0;
            pcol_q   <= 16'd0;
            prow_q   <= 16'd0;
            psof_q   <= 1'b0;
            peol_q   <= 1'b0;
            peof_q   <= 1'b0;
            perr_h_q <= 1'b0;
            perr_v_q <= 1'b0;
        end else begin
            pv_q     <= pv_d;
            pr_q     <= pr_d;
            pg_q     <= pg_d;
            pb_q     <= pb_d;
            pcol_q   <= pcol_d;
            prow_q   <= prow_d;
            psof_q   <= psof_d;
            peol_q   <= peol_d;
            peof_q   <= peof_d;
            perr_h_q <= perr_h_d;
            perr_v_q <= perr_v_d;
        end
    end

    // Output stage: pixel at edge N+2; lock follows the counter by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vid.o_pix_valid <= 1'b0;
            vid.o_Red       <= 8'd0;
            vid.o_Green     <= 8'd0;
            vid.o_Blue      <= 8'd0;
            vid.o_col       <= 16'd0;
            vid.o_row       <= 16'd0;
            vid.o_sof       <= 1'b0;
            vid.o_eol       <= 1'b0;
            vid.o_eof       <= 1'b0;
            vid.o_locked    <= 1'b0;
            vid.o_err_h     <= 1'b0;
            vid.o_err_v     <= 1'b0;
        end else begin
            vid.o_pix_valid <= pv_q;
            vid.o_Red       <= pr_q;
            vid.o_Green     <= pg_q;
            vid.o_Blue      <= pb_q;
            vid.o_col       <= pcol_q;
            vid.o_row       <= prow_q;
            vid.o_sof       <= psof_q;
            vid.o_eol       <= peol_q;
            vid.o_eof       <= peof_q;
            vid.o_locked    <= (cnt_q == LOCK_N);
            vid.o_err_h     <= perr_h_q;
            vid.o_err_v     <= perr_v_q;
        end
    end

`ifdef RGB_VIDEO_RX_SUM_EN
    logic [23:0] acc_q, acc_d;
    logic [9:0]  psum;

    // By the output edge of the eof pixel, acc_q already includes that pixel.
    always_comb begin
        psum  = {2'b00, r_q} + {2'b00, g_q} + {2'b00, b_q};
        acc_d = acc_q;
        if (vs_fall) begin
            acc_d = 24'd0;
        end else if (fwd) begin
            acc_d = acc_q + {14'd0, psum};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q           <= 24'd0;
            vid.o_frame_sum <= 24'd0;
        end else begin
            acc_q <= acc_d;
            if (pv_q && peof_q) begin
                vid.o_frame_sum <= acc_q;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rgb_video_rx.sv
// tb/tb_rgb_video_rx.sv - randomized frame stimulus against a frame-level reference model.
module tb_rgb_video_rx;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgb_video_rx_if vif ();

    rgb_video_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .vid     (vif)
    );

    typedef struct {
        int          col;
        int          row;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        bit          sof;
        bit          eol;
        bit          eof;
        logic [23:0] sum;
    } pix_t;

    pix_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          obs_err_h = 0, obs_err_v = 0;
    int          exp_err_h = 0, exp_err_v = 0;
    bit          synced = 0;
    bit          frame_err = 0;
    int          lines = 0;
    int          clean = 0;
    logic [23:0] msum = 24'd0;
    logic [7:0]  last_r = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (vif.o_err_h) obs_err_h++;
            if (vif.o_err_v) obs_err_v++;
            if (vif.o_pix_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("col", vif.o_col, e.col);
                    chk("row", vif.o_row, e.row);
                    chk("rgb", {vif.o_Red, vif.o_Green, vif.o_Blue}, {e.r, e.g, e.b});
                    chk("markers", {vif.o_sof, vif.o_eol, vif.o_eof}, {e.sof, e.eol, e.eof});
`ifdef RGB_VIDEO_RX_SUM_EN
                    if (e.eof) chk("frame_sum", vif.o_frame_sum, e.sum);
`endif
                    last_r = e.r;
                end
            end else begin
                chk("hold_red", vif.o_Red, last_r);
                chk("idle_markers", {vif.o_sof, vif.o_eol, vif.o_eof}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vif.i_DE = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, vif.o_pix_valid, 32'd0);
        chk({tag, "_rgb"}, {vif.o_Red, vif.o_Green, vif.o_Blue}, 32'd0);
        chk({tag, "_coord"}, {vif.o_col, vif.o_row}, 32'd0);
        chk({tag, "_flags"}, {vif.o_sof, vif.o_eol, vif.o_eof, vif.o_err_h, vif.o_err_v}, 32'd0);
        chk({tag, "_locked"}, vif.o_locked, 32'd0);
`ifdef RGB_VIDEO_RX_SUM_EN
        chk({tag, "_sum"}, vif.o_frame_sum, 32'd0);
`endif
    endtask

    task automatic do_reset_mid();
        rst_n = 1'b0;
        #1;
        check_zero("midline_reset");
        synced = 0; lines = 0; clean = 0; frame_err = 0;
        exp_q.delete();
        last_r = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // The VS fall closes the running frame and opens the next one.
    task automatic vs_pulse();
        if (synced) begin
            if (lines < V) begin
                exp_err_v++;
                clean = 0;
            end else if (!frame_err && clean < LF) begin
                clean++;
            end
        end
        synced = 1; lines = 0; frame_err = 0; msum = 24'd0;
        vif.i_VS = 1'b0;
        repeat (3) tick();
        vif.i_VS = 1'b1;
        repeat (2) tick();
    endtask

    task automatic line(input int len, input int mode, input int rst_at);
        vif.i_DE = 1'b1;
        for (int c = 0; c < len; c++) begin
            logic [7:0] r, g, b;
            case (mode)
                0:       begin r = 8'(c); g = 8'($urandom); b = 8'($urandom); end
                1:       begin r = 8'd1; g = 8'd1; b = 8'd1; end
                default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
            endcase
            vif.i_Red = r; vif.i_Green = g; vif.i_Blue = b;
            if (c == rst_at) do_reset_mid();
            if (synced && lines < V && c < H) begin
                pix_t e;
                msum = msum + 24'(r) + 24'(g) + 24'(b);
                e.col = c; e.row = lines; e.r = r; e.g = g; e.b = b;
                e.sof = (c == 0 && lines == 0);
                e.eol = (c == H - 1);
                e.eof = (c == H - 1 && lines == V - 1);
                e.sum = msum;
                exp_q.push_back(e);
            end
            tick();
        end
        vif.i_DE = 1'b0;
        if (synced) begin
            if (lines < V) begin
                if (len != H) begin
                    exp_err_h++; clean = 0; frame_err = 1;
                end
            end else begin
                exp_err_v++; clean = 0; frame_err = 1;
            end
            lines++;
        end
        idle(3);
    endtask

    task automatic frame(input int nlines, input int bad_row, input int bad_len,
                         input int mode, input int rst_row);
        for (int l = 0; l < nlines; l++)
            line((l == bad_row) ? bad_len : H, mode, (l == rst_row) ? 3 : -1);
        vs_pulse();
    endtask

    task automatic checkpoint(input string tag);
        idle(4);
        chk({tag, "_err_h_count"}, obs_err_h, exp_err_h);
        chk({tag, "_err_v_count"}, obs_err_v, exp_err_v);
        chk({tag, "_locked"}, vif.o_locked, (clean == LF) ? 32'd1 : 32'd0);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        vif.i_HS = 1'b1; vif.i_VS = 1'b1; vif.i_DE = 1'b0;
        vif.i_Red = 8'd0; vif.i_Green = 8'd0; vif.i_Blue = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(3);

        line(H, 2, -1);
        checkpoint("presync");
        vs_pulse();

        for (int f = 0; f < 3; f++) begin
            frame(V, -1, 0, 0, -1);
            checkpoint("clean");
        end

        frame(V, 2, 10, 0, -1);
        checkpoint("long_line");
        frame(V, -1, 0, 2, -1);
        checkpoint("relock1");
        frame(V, -1, 0, 2, -1);
        checkpoint("relock2");

        frame(3, -1, 0, 2, -1);
        checkpoint("short_frame");
        frame(V, -1, 0, 2, -1);
        checkpoint("after_short");

        frame(5, -1, 0, 2, -1);
        checkpoint("extra_line");

        for (int f = 0; f < 6; f++) begin
            frame($urandom_range(3, 5), $urandom_range(0, 5), $urandom_range(6, 10), 2, -1);
            checkpoint("random");
        end

        frame(V, -1, 0, 1, -1);
        checkpoint("ones");
        frame(V, -1, 0, 2, -1);
        checkpoint("pre_reset");

        frame(V, -1, 0, 2, 1);
        checkpoint("post_reset");
        frame(V, -1, 0, 0, -1);
        checkpoint("resync");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rgb_video_rx.md
RGB_VIDEO_RX -- requirements
Module: rgb_video_rx

Interface
REQ-001 Parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive clean frames required before lock.
REQ-004 i_clk  in  1  pixel clock; the only clock.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_HS, i_VS  in  1 each  sync inputs, active low.
REQ-007 i_DE  in  1  data enable, active high.
REQ-008 i_Red, i_Green, i_Blue  in  8 each  pixel data, valid while i_DE high.
REQ-009 o_pix_valid  out  1  high for each forwarded pixel.
REQ-010 o_Red, o_Green, o_Blue  out  8 each  forwarded pixel data.
REQ-011 o_col, o_row  out  16 each  coordinate of the forwarded pixel.
REQ-012 o_sof, o_eol, o_eof  out  1 each  markers qualified by o_pix_valid.
REQ-013 o_locked  out  1  frame geometry stable.
REQ-014 o_err_h, o_err_v  out  1 each  one-cycle error pulses.

Function
REQ-015 All inputs SHALL be registered once; all outputs SHALL be registered; a pixel sampled with i_DE high at edge N SHALL appear with o_pix_valid at edge N+2.
REQ-016 A VS falling edge is the sampled transition from i_VS high to low; DE rise and fall are detected the same way on i_DE. i_HS SHALL be ignored beyond input registering.
REQ-017 States: SEEK (wait VS fall), VBLANK (wait DE rise), LINE (DE high), HGAP (DE low between lines), DRAIN (frame complete; wait VS fall).
REQ-018 SEEK->VBLANK on VS fall; VBLANK->LINE on DE rise; LINE->HGAP on DE fall; HGAP->LINE on DE rise; LINE->DRAIN on DE fall when row V_ACTIVE-1 ends; DRAIN->VBLANK on VS fall.
REQ-019 In LINE, col SHALL increment per pixel from 0; pixels with col < H_ACTIVE SHALL be forwarded; extra pixels SHALL be dropped (o_pix_valid low) and col SHALL saturate at H_ACTIVE.
REQ-020 On DE fall, a line length not equal to H_ACTIVE SHALL pulse o_err_h; row SHALL increment regardless.
REQ-021 o_sof SHALL accompany pixel (0,0); o_eol SHALL accompany col H_ACTIVE-1; o_eof SHALL accompany (H_ACTIVE-1, V_ACTIVE-1).
REQ-022 A VS fall in VBLANK, LINE or HGAP (short frame) SHALL pulse o_err_v and enter VBLANK with row and col cleared.
REQ-023 A DE rise in DRAIN (extra line) SHALL pulse o_err_v; its pixels SHALL be dropped.
REQ-024 Frame-clean counter: increments at each VS fall in DRAIN when the frame raised no error, saturating at LOCK_FRAMES; any o_err_h or o_err_v pulse SHALL clear it and o_locked.
REQ-025 o_locked SHALL assert the cycle after the counter reaches LOCK_FRAMES.
REQ-026 Pixels SHALL be forwarded whether or not o_locked is high.
REQ-027 o_Red, o_Green, o_Blue SHALL hold their last value while o_pix_valid is low.

Reset
REQ-028 Asserting i_rst_n low at any time, including mid-line, SHALL immediately force state SEEK, clear the counters, and drive every output to 0.
REQ-029 After reset release, no pixel SHALL be forwarded before the first VS fall.

Configuration
REQ-030 Macro RGB_VIDEO_RX_SUM_EN: when defined, adds output o_frame_sum [23:0], the modulo-2^24 sum of (Red+Green+Blue) over forwarded pixels. It is latched at o_eof and cleared to 0 at reset. The accumulator clears at each VS fall.
REQ-031 When RGB_VIDEO_RX_SUM_EN is undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Verification (bench parameters: H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=2)
REQ-032 Reset release, then three clean 8x4 frames with pixel value = col -> 32 valids per frame; sof at (0,0), eol at col 7, eof at (7,3); o_locked rises after the 2nd frame's closing VS fall.
REQ-033 Line 2 carries 10 pixels -> cols 8 and 9 dropped; one o_err_h at DE fall; o_locked drops; relock after 2 further clean frames.
REQ-034 VS fall after 3 lines -> one o_err_v; state VBLANK; the next frame starts at row 0.
REQ-035 5th line within a frame -> one o_err_v; no valids for that line.
REQ-036 i_rst_n pulsed low mid-line 1 -> all outputs 0 immediately; no valids until after the next VS fall.
REQ-037 With RGB_VIDEO_RX_SUM_EN, all pixels R=G=B=1 -> o_frame_sum = 96 at eof.
